elevator_ctrl: RTL
==================

Name: elevator_ctrl

Overview:
Cab controller that sits between the button request latches and the cab/door plant model (test_module).
- Consumes pending request vectors and plant sensors.
- Drives `engine` and `door` commands to the plant.
- Returns one-cycle clear pulses to the button block for served requests.
- Implements collective (same-direction-first) scheduling with door open/hold/close sequencing.

Parameters:
- `LEVELS`, 8: number of floors; width of all request/clear vectors.
- `FLOOR_W`, 3: width of floor index; must satisfy 2**FLOOR_W >= LEVELS.
- `DOOR_HOLD`, 20: clk cycles the door stays fully open before a close is commanded.
- `DOOR_TIMEOUT`, 64: cycles allowed for a door movement; used only with the optional feature.

Ports:
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_in` input LEVELS: pending in-cab requests, one bit per floor.
- `req_up` input LEVELS: pending hall up-call requests.
- `req_down` input LEVELS: pending hall down-call requests.
- `sensor_door` input 2: door state; 01 fully open, 10 fully closed, 00 in motion, 11 invalid.
- `sensor_up` input 1: one-cycle pulse when the cab reaches the next floor upward.
- `sensor_down` input 1: one-cycle pulse when the cab reaches the next floor downward.
- `engine` output 2: motor command; 00 stop, 01 up, 10 down (11 never driven).
- `door` output 2: door command; 00 idle, 01 open, 10 close (11 never driven).
- `inactivate_in_levels` output LEVELS: one-cycle clear pulses for `req_in`.
- `inactivate_out_up_levels` output LEVELS: one-cycle clear pulses for `req_up`.
- `inactivate_out_down_levels` output LEVELS: one-cycle clear pulses for `req_down`.
- `floor` output FLOOR_W: current cab floor.
- `dir_up` output 1: current service direction; 1 = up.

Behaviour:
- Reset (async, `reset`=0): state IDLE, `floor`=0, `dir_up`=1, `engine`=00, `door`=00, all clear vectors 0, hold counter 0. Door is taken as closed.
- All outputs are registered.
- Derived signals (combinational):
  - `any_req` = OR of all three vectors.
  - `above` = any request at floor > `floor`.
  - `below` = any request at floor < `floor`.
  - `here` = `req_in[floor]` | `req_up[floor]` | `req_down[floor]`.
- IDLE:
  - If `here`: go to OPEN.
  - Else if `above`: `dir_up`=1, go to CLOSE.
  - Else if `below`: `dir_up`=0, go to CLOSE.
  - Else stay; `engine`=00, `door`=00.
- CLOSE:
  - `door`=10 until `sensor_door`==10.
  - Then `door`=00. `engine`=01 if `dir_up` (go to MOVE_UP), else `engine`=10 (go to MOVE_DOWN).
- MOVE_UP:
  - On `sensor_up`: `floor`<=`floor`+1.
  - Stop at the new floor f if `req_in[f]` | `req_up[f]` | (`req_down[f]` and no request above f).
  - On stop: `engine`=00 in the same cycle the floor updates; go to OPEN.
  - Saturation: at `floor`==LEVELS-1, `sensor_up` is ignored and the cab always stops.
- MOVE_DOWN: mirror of MOVE_UP, using `req_down` and the "no request below" term.
  - Saturation: `floor` stays at 0; `sensor_down` at floor 0 is ignored.
- Sensor rules:
  - `sensor_up` and `sensor_down` asserted together are ignored.
  - A sensor pulse in a non-moving state is ignored.
- OPEN:
  - `door`=01 until `sensor_door`==01.
  - Then pulse clears for this floor: `inactivate_in_levels[floor]` always; the up clear if `dir_up` or no request below; the down clear if `dir_up`=0 or no request above.
  - Load hold counter with DOOR_HOLD; go to HOLD.
- HOLD:
  - `door`=00; counter decrements.
  - A new `here` request reloads the counter and re-pulses the clears.
  - At 0: if `above`/`below` in the current direction, go to CLOSE; else reverse `dir_up` if the opposite side has requests and go to CLOSE; else go to CLOSE and then IDLE.
- Clear pulses are exactly 1 cycle wide; the button block clears next edge. Request bits still high one cycle after a clear are tolerated (no double service).
- `sensor_door`==11 is treated as 00 (wait).
- Reset mid-motion forces `engine`=00 asynchronously.

Optional Feature:
- Macro `DOOR_WATCHDOG_EN`.
- When defined:
  - Adds output port `fault` (1 bit).
  - A counter runs in OPEN and CLOSE; if the target `sensor_door` value is not reached within DOOR_TIMEOUT cycles, go to FAULT.
  - In FAULT: `engine`=00, `door`=00, `fault`=1, sticky until reset.
- When undefined: no `fault` port, no FAULT state; OPEN and CLOSE wait indefinitely.

Test Plan:
1. Reset pulse then idle with no requests -> `engine`=00, `door`=00, `floor`=0, `dir_up`=1, all clears 0, for 100 cycles.
2. `req_in[3]`=1 at floor 0 -> CLOSE, `engine`=01, three `sensor_up` pulses, `floor`=3, `engine`=00, `door`=01, `inactivate_in_levels`=8'b0000_1000 for 1 cycle after `sensor_door`=01.
3. At floor 5, `req_up[2]` and `req_down[6]` set while moving up toward 6 -> stops at 6 first and clears down[6] (no request above); then `dir_up`=0, travels to 2 and clears up[2].
4. `req_up[7]` from floor 6 -> `floor` saturates at 7; extra `sensor_up` at 7 leaves `floor`=7.
5. During HOLD at floor 4, `req_in[4]` re-asserted -> hold counter reloads and the door remains open DOOR_HOLD cycles more.
6. `DOOR_WATCHDOG_EN` defined, `sensor_door` held 00 after a close command -> `fault`=1 after DOOR_TIMEOUT=64 cycles, `engine`=00, held until `reset`=0.

Source files
------------

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: cab controller with collective (same-direction-first) scheduling,
// door open/hold/close sequencing and one-cycle request clear pulses.
// Optional build macro DOOR_WATCHDOG_EN adds a door-movement watchdog, the FAULT
// state and the sticky `fault` output.
module elevator_ctrl #(
    parameter int unsigned LEVELS       = 8,
    parameter int unsigned FLOOR_W      = 3,
    parameter int unsigned DOOR_HOLD    = 20,
    parameter int unsigned DOOR_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVELS-1:0]  req_in,
    input  logic [LEVELS-1:0]  req_up,
    input  logic [LEVELS-1:0]  req_down,
    input  logic [1:0]         sensor_door,
    input  logic               sensor_up,
    input  logic               sensor_down,
    output logic [1:0]         engine,
    output logic [1:0]         door,
    output logic [LEVELS-1:0]  inactivate_in_levels,
    output logic [LEVELS-1:0]  inactivate_out_up_levels,
    output logic [LEVELS-1:0]  inactivate_out_down_levels,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up
`ifdef DOOR_WATCHDOG_EN
    ,
    output logic               fault
`endif
);

    localparam logic [1:0] ENG_STOP     = 2'b00;
    localparam logic [1:0] ENG_UP       = 2'b01;
    localparam logic [1:0] ENG_DOWN     = 2'b10;
    localparam logic [1:0] DOOR_IDLE    = 2'b00;
    localparam logic [1:0] DOOR_OPEN    = 2'b01;
    localparam logic [1:0] DOOR_CLOSE   = 2'b10;
    localparam logic [1:0] SENSE_OPEN   = 2'b01;
    localparam logic [1:0] SENSE_CLOSED = 2'b10;

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(LEVELS - 1);
    localparam int unsigned        HOLD_W    = $clog2(DOOR_HOLD + 1);
`ifdef DOOR_WATCHDOG_EN
    localparam int unsigned        WD_W      = $clog2(DOOR_TIMEOUT + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLOSE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_OPEN,
        S_HOLD
`ifdef DOOR_WATCHDOG_EN
        ,
        S_FAULT
`endif
    } state_t;

    state_t              state, state_n;
    logic [FLOOR_W-1:0]  floor_n;
    logic                dir_n;
    logic [1:0]          engine_n, door_n;
    logic [LEVELS-1:0]   clr_in_n, clr_up_n, clr_dn_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic                idle_after, idle_after_n;
`ifdef DOOR_WATCHDOG_EN
    logic [WD_W-1:0]     wd_cnt, wd_n;
    logic                fault_n;
`endif

    logic [LEVELS-1:0]   all_req, floor_bit;
    logic [FLOOR_W-1:0]  up_f, dn_f;
    logic                above, below, here;
    logic                stop_up, stop_dn, sens_up, sens_dn;
    logic                clr_up_here, clr_dn_here, here_svc;

    function automatic logic any_above(input logic [FLOOR_W-1:0] f, input logic [LEVELS-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < LEVELS; i++)
            if (i > 32'(f) && r[i]) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic any_below(input logic [FLOOR_W-1:0] f, input logic [LEVELS-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < LEVELS; i++)
            if (i < 32'(f) && r[i]) hit = 1'b1;
        return hit;
    endfunction

    // Request summaries relative to the current floor and the floor about to be reached.
    always_comb begin
        all_req     = req_in | req_up | req_down;
        floor_bit   = LEVELS'(1) << floor;
        above       = any_above(floor, all_req);
        below       = any_below(floor, all_req);
        here        = req_in[floor] | req_up[floor] | req_down[floor];
        up_f        = floor + 1'b1;
        dn_f        = floor - 1'b1;
        stop_up     = (up_f == TOP_FLOOR) | req_in[up_f] | req_up[up_f]
                    | (req_down[up_f] & ~any_above(up_f, all_req));
        stop_dn     = (dn_f == '0) | req_in[dn_f] | req_down[dn_f]
                    | (req_up[dn_f] & ~any_below(dn_f, all_req));
        sens_up     = sensor_up & ~sensor_down;
        sens_dn     = sensor_down & ~sensor_up;
        clr_up_here = dir_up | ~below;
        clr_dn_here = ~dir_up | ~above;
        // Only requests this stop would clear count as new, and bits still being
        // cleared this cycle are masked so a stale request is not served twice.
        here_svc    = (req_in[floor] & ~inactivate_in_levels[floor])
                    | (req_up[floor] & clr_up_here & ~inactivate_out_up_levels[floor])
                    | (req_down[floor] & clr_dn_here & ~inactivate_out_down_levels[floor]);
    end

    // Next-state and next-output logic for the cab sequencer.
    always_comb begin
        state_n      = state;
        floor_n      = floor;
        dir_n        = dir_up;
        engine_n     = ENG_STOP;
        door_n       = DOOR_IDLE;
        clr_in_n     = '0;
        clr_up_n     = '0;
        clr_dn_n     = '0;
        hold_n       = hold_cnt;
        idle_after_n = idle_after;
`ifdef DOOR_WATCHDOG_EN
        wd_n         = '0;
        fault_n      = fault;
`endif
        case (state)
            S_IDLE: begin
                if (here) begin
                    state_n = S_OPEN;
                    door_n  = DOOR_OPEN;
                end else if (above) begin
                    dir_n        = 1'b1;
                    state_n      = S_CLOSE;
                    door_n       = DOOR_CLOSE;
                    idle_after_n = 1'b0;
                end else if (below) begin
                    dir_n        = 1'b0;
                    state_n      = S_CLOSE;
                    door_n       = DOOR_CLOSE;
                    idle_after_n = 1'b0;
                end
            end
            S_CLOSE: begin
                if (sensor_door == SENSE_CLOSED) begin
                    idle_after_n = 1'b0;
                    if (idle_after) begin
                        state_n = S_IDLE;
                    end else if (dir_up) begin
                        state_n  = S_MOVE_UP;
                        engine_n = ENG_UP;
                    end else begin
                        state_n  = S_MOVE_DOWN;
                        engine_n = ENG_DOWN;
                    end
                end else begin
                    door_n = DOOR_CLOSE;
`ifdef DOOR_WATCHDOG_EN
                    if (wd_cnt == WD_W'(DOOR_TIMEOUT - 1)) begin
                        state_n = S_FAULT;
                        door_n  = DOOR_IDLE;
                        fault_n = 1'b1;
                    end else begin
                        wd_n = wd_cnt + 1'b1;
                    end
`endif
                end
            end
            S_MOVE_UP: begin
                engine_n = ENG_UP;
                if (floor == TOP_FLOOR) begin
                    engine_n = ENG_STOP;
                    state_n  = S_OPEN;
                    door_n   = DOOR_OPEN;
                end else if (sens_up) begin
                    floor_n = up_f;
                    if (stop_up) begin
                        engine_n = ENG_STOP;
                        state_n  = S_OPEN;
                        door_n   = DOOR_OPEN;
                    end
                end
            end
            S_MOVE_DOWN: begin
                engine_n = ENG_DOWN;
                if (floor == '0) begin
                    engine_n = ENG_STOP;
                    state_n  = S_OPEN;
                    door_n   = DOOR_OPEN;
                end else if (sens_dn) begin
                    floor_n = dn_f;
                    if (stop_dn) begin
                        engine_n = ENG_STOP;
                        state_n  = S_OPEN;
                        door_n   = DOOR_OPEN;
                    end
                end
            end
            S_OPEN: begin
                if (sensor_door == SENSE_OPEN) begin
                    clr_in_n = floor_bit;
                    if (clr_up_here) clr_up_n = floor_bit;
                    if (clr_dn_here) clr_dn_n = floor_bit;
                    hold_n  = HOLD_W'(DOOR_HOLD);
                    state_n = S_HOLD;
                end else begin
                    door_n = DOOR_OPEN;
`ifdef DOOR_WATCHDOG_EN
                    if (wd_cnt == WD_W'(DOOR_TIMEOUT - 1)) begin
                        state_n = S_FAULT;
                        door_n  = DOOR_IDLE;
                        fault_n = 1'b1;
                    end else begin
                        wd_n = wd_cnt + 1'b1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (here_svc) begin
                    clr_in_n = floor_bit;
                    if (clr_up_here) clr_up_n = floor_bit;
                    if (clr_dn_here) clr_dn_n = floor_bit;
                    hold_n = HOLD_W'(DOOR_HOLD);
                end else if (hold_cnt <= HOLD_W'(1)) begin
                    // Deciding on the last count keeps the door open exactly DOOR_HOLD cycles.
                    hold_n  = '0;
                    state_n = S_CLOSE;
                    door_n  = DOOR_CLOSE;
                    if (dir_up ? above : below) begin
                        dir_n = dir_up;
                    end else if (dir_up ? below : above) begin
                        dir_n = ~dir_up;
                    end else begin
                        idle_after_n = 1'b1;
                    end
                end else begin
                    hold_n = hold_cnt - 1'b1;
                end
            end
`ifdef DOOR_WATCHDOG_EN
            S_FAULT: begin
                fault_n = 1'b1;
            end
`endif
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset parks the cab idle with the motor stopped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                      <= S_IDLE;
            floor                      <= '0;
            dir_up                     <= 1'b1;
            engine                     <= ENG_STOP;
            door                       <= DOOR_IDLE;
            inactivate_in_levels       <= '0;
            inactivate_out_up_levels   <= '0;
            inactivate_out_down_levels <= '0;
            hold_cnt                   <= '0;
            idle_after                 <= 1'b0;
`ifdef DOOR_WATCHDOG_EN
            wd_cnt                     <= '0;
            fault                      <= 1'b0;
`endif
        end else begin
            state                      <= state_n;
            floor                      <= floor_n;
            dir_up                     <= dir_n;
            engine                     <= engine_n;
            door                       <= door_n;
            inactivate_in_levels       <= clr_in_n;
            inactivate_out_up_levels   <= clr_up_n;
            inactivate_out_down_levels <= clr_dn_n;
            hold_cnt                   <= hold_n;
            idle_after                 <= idle_after_n;
`ifdef DOOR_WATCHDOG_EN
            wd_cnt                     <= wd_n;
            fault                      <= fault_n;
`endif
        end
    end

endmodule
